// File: rtl/memory_responder_pkg.sv
// Shared types and address decoding for the X-Makina memory responder.
// The read and write channels both use the same range/alignment check.
package xm_mem_pkg;

    typedef enum logic [1:0] {
        MR_IDLE,
        MR_WAIT,
        MR_RESP
    } mem_resp_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] index;
    } addr_chk_t;

    // Byte address -> word index. Out-of-range indices are rejected, never aliased.
    function automatic addr_chk_t addr_ok(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input logic [31:0] depth);
        addr_chk_t r;
        r.index = (addr - base) >> 1;
        r.valid = !addr[0] && (addr >= base) && (r.index < depth);
        return r;
    endfunction

endpackage

// File: rtl/memory_responder_if.sv
// Request/done bus between the CPU-side interfacers (master) and the memory responder (slave).
interface memory_responder_if #(
    parameter int WORD = 16
);
    logic            MEM_rd_en;
    logic [WORD-1:0] MEM_rd_addr;
    logic            MEM_wr_en;
    logic [WORD-1:0] MEM_wr_addr;
    logic [WORD-1:0] MEM_wr_data;
    logic [WORD-1:0] MEM_data;
    logic            MEM_rd_done;
    logic            MEM_rd_err;
    logic            MEM_wr_done;
    logic            MEM_wr_err;

    modport master (
        output MEM_rd_en, MEM_rd_addr, MEM_wr_en, MEM_wr_addr, MEM_wr_data,
        input  MEM_data, MEM_rd_done, MEM_rd_err, MEM_wr_done, MEM_wr_err
    );

    modport slave (
        input  MEM_rd_en, MEM_rd_addr, MEM_wr_en, MEM_wr_addr, MEM_wr_data,
        output MEM_data, MEM_rd_done, MEM_rd_err, MEM_wr_done, MEM_wr_err
    );
endinterface

// File: rtl/memory_responder_channel.sv
// One request channel: IDLE -> WAIT -> RESP FSM with a fixed wait count, address latch
// and error flag. commit pulses on the clock edge that enters RESP with a valid address.
module mem_resp_channel
    import xm_mem_pkg::*;
#(
    parameter int          LATENCY   = 1,
    parameter int          WORD      = 16,
    parameter int          DEPTH     = 1024,
    parameter int unsigned BASE_ADDR = 0,
    parameter int          IDX_W     = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WORD-1:0]  addr,
    input  logic [WORD-1:0]  payload,
    output logic             commit,
    output logic [IDX_W-1:0] commit_idx,
    output logic [WORD-1:0]  commit_data,
    output logic             done,
    output logic             err
);

    mem_resp_state_t  state, state_n;
    logic [7:0]       cnt, cnt_n;
    logic             accept, to_resp;
    logic [IDX_W-1:0] idx_q;
    logic             err_q;
    logic [WORD-1:0]  payload_q;
    addr_chk_t        live;

    assign live = addr_ok(32'(addr), 32'(BASE_ADDR), 32'(DEPTH));

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        accept  = 1'b0;
        to_resp = 1'b0;
        case (state)
            MR_IDLE: if (en) begin
                accept = 1'b1;
                if (LATENCY == 1) begin
                    state_n = MR_RESP;
                    to_resp = 1'b1;
                end else begin
                    state_n = MR_WAIT;
                    cnt_n   = 8'(LATENCY - 1);
                end
            end
            MR_WAIT: begin
                cnt_n = cnt - 8'd1;
                if (cnt == 8'd1) begin
                    state_n = MR_RESP;
                    to_resp = 1'b1;
                end
            end
            MR_RESP: state_n = MR_IDLE;
            default: state_n = MR_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= MR_IDLE;
            cnt       <= '0;
            idx_q     <= '0;
            err_q     <= 1'b0;
            payload_q <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                idx_q     <= IDX_W'(live.index);
                err_q     <= !live.valid;
                payload_q <= payload;
            end
        end
    end

    // With LATENCY=1 the commit edge is the accept edge, so use the live request then.
    assign commit_idx  = (state == MR_IDLE) ? IDX_W'(live.index) : idx_q;
    assign commit_data = (state == MR_IDLE) ? payload : payload_q;
    assign commit      = to_resp && ((state == MR_IDLE) ? live.valid : !err_q);

    assign done = (state == MR_RESP) && !err_q;
    assign err  = (state == MR_RESP) &&  err_q;

endmodule

// File: rtl/memory_responder.sv
// Memory responder top: word array shared by an independent read and write channel.
// A read and write committing on the same edge see read-before-write ordering.
module memory_responder
    import xm_mem_pkg::*;
#(
    parameter int          WORD       = 16,
    parameter int          DEPTH      = 1024,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int          RD_LATENCY = 2,
    parameter int          WR_LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset,
    memory_responder_if.slave bus
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic             rd_commit, wr_commit, rd_done;
    logic [IDX_W-1:0] rd_idx, wr_idx;
    logic [WORD-1:0]  wr_data, rd_payload_unused;
    logic [WORD-1:0]  rd_data_q;
    logic [WORD-1:0]  mem [DEPTH];

    mem_resp_channel #(
        .LATENCY(RD_LATENCY), .WORD(WORD), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR), .IDX_W(IDX_W)
    ) u_rd (
        .clk         (clk),
        .reset       (reset),
        .en          (bus.MEM_rd_en),
        .addr        (bus.MEM_rd_addr),
        .payload     ('0),
        .commit      (rd_commit),
        .commit_idx  (rd_idx),
        .commit_data (rd_payload_unused),
        .done        (rd_done),
        .err         (bus.MEM_rd_err)
    );

    mem_resp_channel #(
        .LATENCY(WR_LATENCY), .WORD(WORD), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR), .IDX_W(IDX_W)
    ) u_wr (
        .clk         (clk),
        .reset       (reset),
        .en          (bus.MEM_wr_en),
        .addr        (bus.MEM_wr_addr),
        .payload     (bus.MEM_wr_data),
        .commit      (wr_commit),
        .commit_idx  (wr_idx),
        .commit_data (wr_data),
        .done        (bus.MEM_wr_done),
        .err         (bus.MEM_wr_err)
    );

    // NOTE: the array has no reset; contents survive reset and map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_commit) mem[wr_idx] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         rd_data_q <= '0;
        else if (rd_commit) rd_data_q <= mem[rd_idx];
    end

    assign bus.MEM_rd_done = rd_done;
    assign bus.MEM_data    = rd_done ? rd_data_q : '0;

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder (RD_LATENCY=2, WR_LATENCY=1, DEPTH=1024, BASE=0).
// Inputs change 1ns after posedge; outputs are sampled on the falling edge.
module tb_memory_responder;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    memory_responder_if #(.WORD(16)) bus ();

    memory_responder #(
        .WORD(16), .DEPTH(1024), .BASE_ADDR(0), .RD_LATENCY(2), .WR_LATENCY(1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Issue one read at the next edge; report early response, response, error, data at latency 2.
    task automatic do_read(input logic [15:0] a, output logic early, output logic done,
                           output logic err, output logic [15:0] data);
        bus.MEM_rd_en   = 1'b1;
        bus.MEM_rd_addr = a;
        @(posedge clk); #1;
        bus.MEM_rd_en = 1'b0;
        @(negedge clk);
        early = bus.MEM_rd_done | bus.MEM_rd_err;
        @(posedge clk);
        @(negedge clk);
        done = bus.MEM_rd_done;
        err  = bus.MEM_rd_err;
        data = bus.MEM_data;
        @(posedge clk); #1;
    endtask

    // Issue one write at the next edge; report response at latency 1.
    task automatic do_write(input logic [15:0] a, input logic [15:0] d,
                            output logic done, output logic err);
        bus.MEM_wr_en   = 1'b1;
        bus.MEM_wr_addr = a;
        bus.MEM_wr_data = d;
        @(posedge clk); #1;
        bus.MEM_wr_en = 1'b0;
        @(negedge clk);
        done = bus.MEM_wr_done;
        err  = bus.MEM_wr_err;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic e, d, r;
        logic [15:0] q;
        logic [19:0] outs;
        reset = 1'b0;
        bus.MEM_rd_en = 1'b0; bus.MEM_rd_addr = '0;
        bus.MEM_wr_en = 1'b0; bus.MEM_wr_addr = '0; bus.MEM_wr_data = '0;
        #12;
        outs = {bus.MEM_rd_done, bus.MEM_rd_err, bus.MEM_wr_done, bus.MEM_wr_err, bus.MEM_data};
        total++;
        if (outs !== 20'h0) begin bad++; $display("FAIL reset_outputs: got %h want 0", outs); end
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        do_write(16'h0004, 16'h1234, d, r);
        total++;
        if ({d, r} !== 2'b10) begin bad++; $display("FAIL reset_prewrite: done/err=%b want 10", {d, r}); end

        bus.MEM_rd_en = 1'b1; bus.MEM_rd_addr = 16'h0004;
        @(posedge clk); #1;
        bus.MEM_rd_en = 1'b0;
        reset = 1'b0;
        #1;
        outs = {bus.MEM_rd_done, bus.MEM_rd_err, bus.MEM_wr_done, bus.MEM_wr_err, bus.MEM_data};
        total++;
        if (outs !== 20'h0) begin bad++; $display("FAIL reset_midwait_outputs: got %h want 0", outs); end
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total++;
            if ({bus.MEM_rd_done, bus.MEM_rd_err} !== 2'b00) begin
                bad++; $display("FAIL reset_dropped_req cyc%0d: done/err=%b want 00", i,
                                {bus.MEM_rd_done, bus.MEM_rd_err});
            end
        end
        @(posedge clk); #1;

        do_read(16'h0004, e, d, r, q);
        total++;
        if ({e, d, r, q} !== {3'b010, 16'h1234}) begin
            bad++; $display("FAIL reset_next_read: early/done/err=%b data=%h want 010 1234", {e, d, r}, q);
        end
    endtask

    task automatic test_write_read();
        logic e, d, r;
        logic [15:0] q;
        do_write(16'h0010, 16'hBEEF, d, r);
        total++;
        if ({d, r} !== 2'b10) begin bad++; $display("FAIL wr_beef: done/err=%b want 10", {d, r}); end
        do_read(16'h0010, e, d, r, q);
        total++;
        if (e !== 1'b0) begin bad++; $display("FAIL rd_beef_early: got %b want 0", e); end
        total++;
        if ({d, r, q} !== {2'b10, 16'hBEEF}) begin
            bad++; $display("FAIL rd_beef: done/err=%b data=%h want 10 beef", {d, r}, q);
        end
    endtask

    task automatic test_errors();
        logic e, d, r;
        logic [15:0] q;
        do_read(16'h0003, e, d, r, q);
        total++;
        if ({e, d, r, q} !== {3'b001, 16'h0000}) begin
            bad++; $display("FAIL rd_odd: early/done/err=%b data=%h want 001 0000", {e, d, r}, q);
        end
        do_read(16'h0800, e, d, r, q);
        total++;
        if ({e, d, r, q} !== {3'b001, 16'h0000}) begin
            bad++; $display("FAIL rd_past_depth: early/done/err=%b data=%h want 001 0000", {e, d, r}, q);
        end
        do_write(16'h0000, 16'h5A5A, d, r);
        total++;
        if ({d, r} !== 2'b10) begin bad++; $display("FAIL wr_zero: done/err=%b want 10", {d, r}); end
        do_write(16'h0801, 16'hDEAD, d, r);
        total++;
        if ({d, r} !== 2'b01) begin bad++; $display("FAIL wr_0801: done/err=%b want 01", {d, r}); end
        do_write(16'h0011, 16'hDEAD, d, r);
        total++;
        if ({d, r} !== 2'b01) begin bad++; $display("FAIL wr_odd: done/err=%b want 01", {d, r}); end
        do_read(16'h0000, e, d, r, q);
        total++;
        if ({d, r, q} !== {2'b10, 16'h5A5A}) begin
            bad++; $display("FAIL no_alias_0000: done/err=%b data=%h want 10 5a5a", {d, r}, q);
        end
        do_read(16'h0010, e, d, r, q);
        total++;
        if ({d, r, q} !== {2'b10, 16'hBEEF}) begin
            bad++; $display("FAIL odd_wr_untouched: done/err=%b data=%h want 10 beef", {d, r}, q);
        end
    endtask

    task automatic test_same_edge();
        logic e, d, r;
        logic [15:0] q;
        do_write(16'h0020, 16'h1111, d, r);
        bus.MEM_rd_en = 1'b1; bus.MEM_rd_addr = 16'h0020;
        @(posedge clk); #1;
        bus.MEM_rd_en = 1'b0;
        bus.MEM_wr_en = 1'b1; bus.MEM_wr_addr = 16'h0020; bus.MEM_wr_data = 16'h2222;
        @(negedge clk);
        total++;
        if (bus.MEM_rd_done !== 1'b0) begin bad++; $display("FAIL same_edge_wait: rd_done=%b want 0", bus.MEM_rd_done); end
        @(posedge clk); #1;
        bus.MEM_wr_en = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.MEM_rd_done, bus.MEM_wr_done, bus.MEM_data} !== {2'b11, 16'h1111}) begin
            bad++; $display("FAIL same_edge_rbw: rd_done/wr_done=%b data=%h want 11 1111",
                            {bus.MEM_rd_done, bus.MEM_wr_done}, bus.MEM_data);
        end
        @(posedge clk); #1;
        do_read(16'h0020, e, d, r, q);
        total++;
        if ({d, r, q} !== {2'b10, 16'h2222}) begin
            bad++; $display("FAIL same_edge_after: done/err=%b data=%h want 10 2222", {d, r}, q);
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] exp;
        // Held en: accepts at edges 1,4,7,10 -> responses after edges 2,5,8,11.
        bus.MEM_rd_en = 1'b1; bus.MEM_rd_addr = 16'h0000;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (i == 10) bus.MEM_rd_en = 1'b0;
            @(negedge clk);
            exp = ((i % 3) == 2) ? {2'b10, 16'h5A5A} : 18'h0;
            total++;
            if ({bus.MEM_rd_done, bus.MEM_rd_err, bus.MEM_data} !== exp) begin
                bad++; $display("FAIL held_en cyc%0d: got %h want %h", i,
                                {bus.MEM_rd_done, bus.MEM_rd_err, bus.MEM_data}, exp);
            end
        end
        @(posedge clk); #1;
        // en glitched high during WAIT must not start another request.
        bus.MEM_rd_en = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin bus.MEM_rd_en = 1'b0; #2 bus.MEM_rd_en = 1'b1; end
            if (i == 2) bus.MEM_rd_en = 1'b0;
            @(negedge clk);
            exp = (i == 2) ? {2'b10, 16'h5A5A} : 18'h0;
            total++;
            if ({bus.MEM_rd_done, bus.MEM_rd_err, bus.MEM_data} !== exp) begin
                bad++; $display("FAIL wait_pulse cyc%0d: got %h want %h", i,
                                {bus.MEM_rd_done, bus.MEM_rd_err, bus.MEM_data}, exp);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_boundary();
        logic e, d, r;
        logic [15:0] q, below;
        below = 16'h0000 - 16'h0002;
        do_write(16'h07FE, 16'h7777, d, r);
        total++;
        if ({d, r} !== 2'b10) begin bad++; $display("FAIL wr_top: done/err=%b want 10", {d, r}); end
        do_read(16'h07FE, e, d, r, q);
        total++;
        if ({d, r, q} !== {2'b10, 16'h7777}) begin
            bad++; $display("FAIL rd_top: done/err=%b data=%h want 10 7777", {d, r}, q);
        end
        do_read(16'h0000, e, d, r, q);
        total++;
        if ({d, r, q} !== {2'b10, 16'h5A5A}) begin
            bad++; $display("FAIL rd_base: done/err=%b data=%h want 10 5a5a", {d, r}, q);
        end
        do_read(below, e, d, r, q);
        total++;
        if ({d, r, q} !== {2'b01, 16'h0000}) begin
            bad++; $display("FAIL rd_below_base: done/err=%b data=%h want 01 0000", {d, r}, q);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_errors();
        test_same_edge();
        test_back_to_back();
        test_boundary();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
